wb_cache_control: RTL and testbench
===================================

# wb_cache_control

Parametrised controller for an N-way set-associative, write-back, write-allocate cache. It sits between the CPU-side memory port and physical memory, alongside the cache datapath that holds the tag, data, valid and dirty arrays. It extends the two-way write-through controller with per-way dirty tracking, a write-back state, tree pseudo-LRU replacement with invalid-way priority, and saturating statistics counters.

## Interface

Parameters:
- WAYS, 2: associativity; a power of two, at least 2.
- WAY_W, $clog2(WAYS): way index width.
- CNT_W, 16: width of each statistics counter.

Ports (array-indexed outputs are one-hot or zero):
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  reset; synchronous, active-high.
- mem_read  in  1  CPU read request; held until mem_resp.
- mem_write  in  1  CPU write request; held until mem_resp; wins over mem_read if both are high.
- hit_way  in  WAYS  one-hot tag match of valid ways for the current set; 0 means miss.
- valid_out  in  WAYS  valid bits of the current set.
- dirty_out  in  WAYS  dirty bits of the current set.
- lru_out  in  WAYS-1  tree-PLRU bits of the current set.
- pmem_resp  in  1  physical memory done; single-cycle pulse.
- clear_stats  in  1  zero all counters.
- mem_resp  out  1  CPU access complete.
- pmem_read  out  1  line fill strobe.
- pmem_write  out  1  line write-back strobe.
- pmem_addr_sel  out  1  0 selects the CPU address; 1 selects {victim tag, set}.
- way_sel  out  WAY_W  datapath way mux select.
- data_src_mem  out  1  1 selects the pmem line as data-array input; 0 selects the CPU write data.
- load_tag, load_data, load_valid, load_dirty  out  WAYS each  per-way array write enables.
- valid_in  out  1  valid value written.
- dirty_in  out  1  dirty value written.
- load_lru  out  1  PLRU array write enable.
- lru_in  out  WAYS-1  new PLRU bits.
- hit_count, miss_count, wb_count  out  CNT_W each  saturating statistics.

## Operation

- States: IDLE, WRITE_BACK, ALLOCATE. The state register resets to IDLE. All outputs are combinational from state and inputs. Every output defaults to 0.
- **PLRU tree:**
  - Node n has children 2n+1 and 2n+2, with leaves mapping to ways 0..WAYS-1 left to right.
  - A bit of 0 points the victim left (lower ways); 1 points it right.
  - On an access to way w, every node on w's path is set to point away from w. Nodes off the path keep their lru_out value.
- **Victim selection:** the lowest-index way with valid_out=0 if any exists; otherwise the way reached by following the PLRU bits. The victim is latched into victim_q on the IDLE to miss transition, and victim_q drives way_sel in WRITE_BACK and ALLOCATE.
- **IDLE, request with hit:**
  - Assert mem_resp, set way_sel to the hit way, assert load_lru, and drive lru_in with the PLRU update for the hit way.
  - On a write, also assert load_data and load_dirty for the hit way, with dirty_in=1 and data_src_mem=0.
  - Stay in IDLE.
- **IDLE, request with miss:** go to WRITE_BACK if the victim is valid and dirty, otherwise to ALLOCATE. No array writes occur.
- **WRITE_BACK:** assert pmem_write and pmem_addr_sel=1. On pmem_resp, go to ALLOCATE.
- **ALLOCATE:**
  - Assert pmem_read with pmem_addr_sel=0.
  - On pmem_resp, for the victim way only, assert load_data, load_tag, load_valid and load_dirty, with valid_in=1, dirty_in=0 and data_src_mem=1. Go to IDLE.
  - The access then re-evaluates as a hit, which performs the LRU update and mem_resp.
- **Counters:**
  - hit_count increments on each IDLE hit cycle.
  - miss_count increments on each IDLE to miss transition.
  - wb_count increments on each WRITE_BACK exit.
  - All counters saturate at 2^CNT_W-1.
  - clear_stats and rst zero all counters, taking priority over a same-cycle increment.

## Timing

- Reset: while rst is high, the state is IDLE, victim_q=0 and all counters are 0 from the next edge. Reset mid-WRITE_BACK or mid-ALLOCATE drops pmem_read/pmem_write in the cycle after the edge, and no array writes occur.
- Hit latency: mem_resp is asserted in the same cycle as the request (0 wait states).
- Clean miss: request at cycle 0, ALLOCATE from cycle 1, pmem_resp at cycle k, IDLE at k+1, mem_resp at k+1.
- Dirty miss: WRITE_BACK from cycle 1 and ALLOCATE the cycle after the write-back pmem_resp. Then the same sequence as a clean miss.
- Array load enables are single-cycle pulses.
- A pmem_resp arriving in IDLE is ignored.
- Dropping the request mid-miss is illegal. The controller completes the fill regardless.

## Test plan

- **Reset mid-fill:** WAYS=4, assert rst for 2 cycles during ALLOCATE. Expect pmem_read=0 after the first edge, state IDLE, and all counters 0.
- **Read hit:** hit_way=4'b0100, lru_out=3'b000. Expect mem_resp=1 in the same cycle, load_lru=1, lru_in=3'b100, and hit_count incremented by 1.
- **Clean read miss:** valid_out=4'b1111, dirty_out=0, lru_out=3'b000, pmem_resp 5 cycles after ALLOCATE entry. Expect victim way 0 and a single-cycle load_data/load_tag/load_valid=4'b0001 with valid_in=1 and dirty_in=0. The next cycle is IDLE with mem_resp.
- **Dirty write miss:** valid_out=4'b1111, dirty_out=4'b0010, lru_out=3'b010. Expect victim way 1, WRITE_BACK with pmem_write=1, pmem_addr_sel=1 and way_sel=1, then ALLOCATE. The final hit asserts load_data=load_dirty=4'b0010 with dirty_in=1, and wb_count=1.
- **Invalid-way priority:** valid_out=4'b1011, lru_out=3'b000. Expect victim way 2 and no WRITE_BACK, even if dirty_out[0]=1.
- **Counter saturation:** CNT_W=4. After 20 hits, hit_count=15. clear_stats together with a hit gives hit_count=0 on the next cycle.

Source files
------------

// File: rtl/wb_cache_control.sv
// rtl/wb_cache_control.sv - N-way write-back, write-allocate cache controller with tree PLRU and stats
//
// Purpose: sequences CPU accesses against an N-way set-associative cache
// datapath. Hits complete with zero wait states. Misses optionally write back
// a dirty victim and then fill the line from physical memory. The access then
// replays as a hit.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   mem_read, mem_write      CPU request (held until mem_resp; write wins)
//   hit_way                  one-hot tag match for the current set (0 = miss)
//   valid_out, dirty_out     valid/dirty bits of the current set
//   lru_out                  tree-PLRU bits of the current set
//   pmem_resp                physical memory completion pulse
//   clear_stats              zero all statistics counters
//   mem_resp                 CPU access complete
//   pmem_read, pmem_write    line fill / write-back strobes
//   pmem_addr_sel            0 = CPU address, 1 = {victim tag, set}
//   way_sel                  datapath way mux select
//   data_src_mem             1 = pmem line into data array, 0 = CPU write data
//   load_tag/data/valid/dirty per-way array write enables
//   valid_in, dirty_in       values written to valid/dirty arrays
//   load_lru, lru_in         PLRU array write enable and new bits
//   hit_count, miss_count, wb_count  saturating statistics

module wb_cache_control #(
  parameter int WAYS  = 2,
  parameter int WAY_W = $clog2(WAYS),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [WAYS-1:0]  hit_way,
  input  logic [WAYS-1:0]  valid_out,
  input  logic [WAYS-1:0]  dirty_out,
  input  logic [WAYS-2:0]  lru_out,
  input  logic             pmem_resp,
  input  logic             clear_stats,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic             pmem_addr_sel,
  output logic [WAY_W-1:0] way_sel,
  output logic             data_src_mem,
  output logic [WAYS-1:0]  load_tag,
  output logic [WAYS-1:0]  load_data,
  output logic [WAYS-1:0]  load_valid,
  output logic [WAYS-1:0]  load_dirty,
  output logic             valid_in,
  output logic             dirty_in,
  output logic             load_lru,
  output logic [WAYS-2:0]  lru_in,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WRITE_BACK = 2'd1,
    S_ALLOCATE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;

  logic req;
  logic is_hit;
  logic hit_ev, miss_ev, wb_ev;

  assign req    = mem_read | mem_write;
  assign is_hit = |hit_way;

  // One-hot hit vector to way index.
  logic [WAY_W-1:0] hit_idx;
  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (hit_way[i]) hit_idx = WAY_W'(i);
    end
  end

  // Follow PLRU bits from the root; each level contributes one way-index bit,
  // MSB first, so the leaf reached is the way index directly.
  logic [WAY_W-1:0] plru_way;
  int               walk_node;
  always_comb begin
    walk_node = 0;
    plru_way  = '0;
    for (int l = 0; l < WAY_W; l++) begin
      plru_way[WAY_W-1-l] = lru_out[walk_node[WAY_W-1:0]];
      walk_node = 2 * walk_node + 1 + int'(lru_out[walk_node[WAY_W-1:0]]);
    end
  end

  // Touch the hit way: every node on its path points away from it.
  logic [WAYS-2:0] lru_upd;
  int              upd_node;
  logic            upd_bit;
  always_comb begin
    lru_upd  = lru_out;
    upd_node = 0;
    upd_bit  = 1'b0;
    for (int l = 0; l < WAY_W; l++) begin
      upd_bit = hit_idx[WAY_W-1-l];
      lru_upd[upd_node[WAY_W-1:0]] = ~upd_bit;
      upd_node = 2 * upd_node + 1 + int'(upd_bit);
    end
  end

  // Lowest-index invalid way (scan from the top so the lowest wins).
  logic             has_inv;
  logic [WAY_W-1:0] first_inv;
  always_comb begin
    has_inv   = 1'b0;
    first_inv = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_out[i]) begin
        has_inv   = 1'b1;
        first_inv = WAY_W'(i);
      end
    end
  end

  logic [WAY_W-1:0] victim;
  logic             victim_dirty;
  logic [WAYS-1:0]  victim_oh;

  assign victim       = has_inv ? first_inv : plru_way;
  assign victim_dirty = valid_out[victim] & dirty_out[victim];
  assign victim_oh    = {{(WAYS-1){1'b0}}, 1'b1} << victim_q;

  // Next state and combinational outputs. Outputs are held at zero while rst
  // is high so a pmem_resp coinciding with reset cannot write the arrays.
  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    hit_ev        = 1'b0;
    miss_ev       = 1'b0;
    wb_ev         = 1'b0;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    way_sel       = '0;
    data_src_mem  = 1'b0;
    load_tag      = '0;
    load_data     = '0;
    load_valid    = '0;
    load_dirty    = '0;
    valid_in      = 1'b0;
    dirty_in      = 1'b0;
    load_lru      = 1'b0;
    lru_in        = '0;

    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if (is_hit) begin
              mem_resp = 1'b1;
              way_sel  = hit_idx;
              load_lru = 1'b1;
              lru_in   = lru_upd;
              hit_ev   = 1'b1;
              if (mem_write) begin
                load_data  = hit_way;
                load_dirty = hit_way;
                dirty_in   = 1'b1;
              end
            end else begin
              victim_d = victim;
              miss_ev  = 1'b1;
              state_d  = victim_dirty ? S_WRITE_BACK : S_ALLOCATE;
            end
          end
        end

        S_WRITE_BACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          way_sel       = victim_q;
          if (pmem_resp) begin
            wb_ev   = 1'b1;
            state_d = S_ALLOCATE;
          end
        end

        S_ALLOCATE: begin
          pmem_read = 1'b1;
          way_sel   = victim_q;
          if (pmem_resp) begin
            load_tag     = victim_oh;
            load_data    = victim_oh;
            load_valid   = victim_oh;
            load_dirty   = victim_oh;
            valid_in     = 1'b1;
            data_src_mem = 1'b1;
            state_d      = S_IDLE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  // clear_stats overrides a same-cycle increment.
  always_comb begin
    if (clear_stats) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
      wb_cnt_d   = '0;
    end else begin
      hit_cnt_d  = sat_inc(hit_cnt_q, hit_ev);
      miss_cnt_d = sat_inc(miss_cnt_q, miss_ev);
      wb_cnt_d   = sat_inc(wb_cnt_q, wb_ev);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      victim_q   <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      victim_q   <= victim_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign wb_count   = wb_cnt_q;

endmodule

// File: tb/tb_wb_cache_control.sv
// tb/tb_wb_cache_control.sv - self-checking bench for wb_cache_control

module tb_wb_cache_control;

  localparam int WAYS  = 4;
  localparam int WAY_W = 2;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  // Bit positions inside the packed control snapshot.
  localparam int C_RESP = 7;
  localparam int C_PRD  = 6;
  localparam int C_PWR  = 5;
  localparam int C_ASEL = 4;
  localparam int C_DSRC = 3;
  localparam int C_VIN  = 2;
  localparam int C_DIN  = 1;
  localparam int C_LLRU = 0;

  logic             clk = 1'b0;
  logic             rst;
  logic             mem_read, mem_write;
  logic [WAYS-1:0]  hit_way, valid_out, dirty_out;
  logic [WAYS-2:0]  lru_out;
  logic             pmem_resp, clear_stats;
  logic             mem_resp, pmem_read, pmem_write, pmem_addr_sel;
  logic [WAY_W-1:0] way_sel;
  logic             data_src_mem;
  logic [WAYS-1:0]  load_tag, load_data, load_valid, load_dirty;
  logic             valid_in, dirty_in, load_lru;
  logic [WAYS-2:0]  lru_in;
  logic [CNT_W-1:0] hit_count, miss_count, wb_count;

  always #5 clk = ~clk;

  wb_cache_control #(.WAYS(WAYS), .WAY_W(WAY_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .hit_way(hit_way), .valid_out(valid_out), .dirty_out(dirty_out),
    .lru_out(lru_out), .pmem_resp(pmem_resp), .clear_stats(clear_stats),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_addr_sel(pmem_addr_sel), .way_sel(way_sel), .data_src_mem(data_src_mem),
    .load_tag(load_tag), .load_data(load_data), .load_valid(load_valid),
    .load_dirty(load_dirty), .valid_in(valid_in), .dirty_in(dirty_in),
    .load_lru(load_lru), .lru_in(lru_in),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: phase 0 = idle, 1 = writing back, 2 = filling.
  int m_phase, m_victim, m_hit, m_miss, m_wb;
  bit x_resp;

  // DUT snapshot of the most recent step, for directed checks.
  logic [7:0]  o_ctl;
  logic [15:0] o_ld;
  logic [1:0]  o_way;
  logic [2:0]  o_lru;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < WAYS; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Victim by descending the tree: a 0 bit goes to the left child.
  function automatic int plru_victim(input logic [2:0] lru);
    int n = 0;
    while (n < WAYS - 1) n = 2 * n + 1 + int'(lru[n]);
    return n - (WAYS - 1);
  endfunction

  // Access by climbing from the leaf: each ancestor points to the other child.
  function automatic logic [2:0] plru_touch(input logic [2:0] lru, input int w);
    logic [2:0] r = lru;
    int n = w + WAYS - 1;
    while (n > 0) begin
      int p = (n - 1) / 2;
      r[p] = (n % 2 == 1);
      n = p;
    end
    return r;
  endfunction

  function automatic int pick_victim(input logic [3:0] vld, input logic [2:0] lru);
    for (int i = 0; i < WAYS; i++) if (!vld[i]) return i;
    return plru_victim(lru);
  endfunction

  // One clock cycle: apply inputs, compare outputs to the model, advance.
  task automatic step(input logic r, input logic w, input logic [3:0] hit,
                      input logic [3:0] vld, input logic [3:0] drt,
                      input logic [2:0] lru, input logic resp,
                      input logic clr, input logic rs);
    logic [7:0]  e_ctl;
    logic [3:0]  e_tag, e_data, e_valid, e_dirty;
    int          e_way;
    logic [2:0]  e_lru;
    int          n_phase, n_victim, hi;
    bit          hit_ev, miss_ev, wb_ev;

    mem_read = r; mem_write = w; hit_way = hit; valid_out = vld;
    dirty_out = drt; lru_out = lru; pmem_resp = resp; clear_stats = clr; rst = rs;
    #1;

    e_ctl = '0; e_tag = '0; e_data = '0; e_valid = '0; e_dirty = '0;
    e_way = 0; e_lru = '0;
    n_phase = m_phase; n_victim = m_victim;
    hit_ev = 0; miss_ev = 0; wb_ev = 0;

    if (rs) begin
      n_phase = 0;
      n_victim = 0;
    end else if (m_phase == 0) begin
      if (r || w) begin
        if (hit != 0) begin
          hi = oh_idx(hit);
          e_ctl[C_RESP] = 1'b1;
          e_ctl[C_LLRU] = 1'b1;
          e_way = hi;
          e_lru = plru_touch(lru, hi);
          hit_ev = 1;
          if (w) begin
            e_data = hit;
            e_dirty = hit;
            e_ctl[C_DIN] = 1'b1;
          end
        end else begin
          n_victim = pick_victim(vld, lru);
          n_phase = (vld[n_victim] && drt[n_victim]) ? 1 : 2;
          miss_ev = 1;
        end
      end
    end else if (m_phase == 1) begin
      e_ctl[C_PWR] = 1'b1;
      e_ctl[C_ASEL] = 1'b1;
      e_way = m_victim;
      if (resp) begin
        n_phase = 2;
        wb_ev = 1;
      end
    end else begin
      e_ctl[C_PRD] = 1'b1;
      e_way = m_victim;
      if (resp) begin
        e_tag = 4'b0001 << m_victim;
        e_data = e_tag; e_valid = e_tag; e_dirty = e_tag;
        e_ctl[C_VIN] = 1'b1;
        e_ctl[C_DSRC] = 1'b1;
        n_phase = 0;
      end
    end

    o_ctl = {mem_resp, pmem_read, pmem_write, pmem_addr_sel,
             data_src_mem, valid_in, dirty_in, load_lru};
    o_ld  = {load_tag, load_data, load_valid, load_dirty};
    o_way = way_sel;
    o_lru = lru_in;
    x_resp = e_ctl[C_RESP];

    check("ctl", 32'(o_ctl), 32'(e_ctl));
    check("loads", 32'(o_ld), 32'({e_tag, e_data, e_valid, e_dirty}));
    check("way_sel", 32'(o_way), 32'(e_way));
    check("lru_in", 32'(o_lru), 32'(e_lru));
    check("hit_count", 32'(hit_count), 32'(m_hit));
    check("miss_count", 32'(miss_count), 32'(m_miss));
    check("wb_count", 32'(wb_count), 32'(m_wb));

    @(posedge clk);
    #1;
    m_phase = n_phase;
    m_victim = n_victim;
    if (rs || clr) begin
      m_hit = 0; m_miss = 0; m_wb = 0;
    end else begin
      if (hit_ev && m_hit < CMAX) m_hit++;
      if (miss_ev && m_miss < CMAX) m_miss++;
      if (wb_ev && m_wb < CMAX) m_wb++;
    end
  endtask

  logic       hr, hw;
  logic [3:0] s_hit, s_vld, s_drt;
  logic [2:0] s_lru;
  logic       s_resp, s_clr, s_rs;
  int         sel;

  initial begin
    m_phase = 0; m_victim = 0; m_hit = 0; m_miss = 0; m_wb = 0;
    rst = 1'b1; mem_read = 0; mem_write = 0; hit_way = 0; valid_out = 0;
    dirty_out = 0; lru_out = 0; pmem_resp = 0; clear_stats = 0;
    @(posedge clk);
    #1;

    // Reset state.
    step(0, 0, 4'b0000, 4'hf, 4'h0, 3'b000, 0, 0, 1);
    check("rst_hit_count", 32'(hit_count), 0);
    check("rst_miss_count", 32'(miss_count), 0);

    // Read hit on way 2.
    step(1, 0, 4'b0100, 4'hf, 4'h0, 3'b000, 0, 0, 0);
    check("rh_resp", 32'(o_ctl[C_RESP]), 1);
    check("rh_load_lru", 32'(o_ctl[C_LLRU]), 1);
    check("rh_lru_in", 32'(o_lru), 32'(3'b100));
    check("rh_hit_count", 32'(hit_count), 1);

    // Clean read miss, fill 5 cycles after entering ALLOCATE.
    step(1, 0, 4'b0000, 4'hf, 4'h0, 3'b000, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 4'b0000, 4'hf, 4'h0, 3'b000, 0, 0, 0);
    check("cm_pmem_read", 32'(o_ctl[C_PRD]), 1);
    step(1, 0, 4'b0000, 4'hf, 4'h0, 3'b000, 1, 0, 0);
    check("cm_loads", 32'(o_ld), 32'(16'h1111));
    check("cm_valid_in", 32'(o_ctl[C_VIN]), 1);
    check("cm_dirty_in", 32'(o_ctl[C_DIN]), 0);
    step(1, 0, 4'b0001, 4'hf, 4'h0, 3'b000, 0, 0, 0);
    check("cm_final_resp", 32'(o_ctl[C_RESP]), 1);
    check("cm_final_loads", 32'(o_ld), 0);

    // Dirty write miss, victim way 1.
    step(0, 1, 4'b0000, 4'hf, 4'b0010, 3'b010, 0, 0, 0);
    step(0, 1, 4'b0000, 4'hf, 4'b0010, 3'b010, 0, 0, 0);
    check("dm_pmem_write", 32'(o_ctl[C_PWR]), 1);
    check("dm_addr_sel", 32'(o_ctl[C_ASEL]), 1);
    check("dm_way_sel", 32'(o_way), 1);
    step(0, 1, 4'b0000, 4'hf, 4'b0010, 3'b010, 1, 0, 0);
    step(0, 1, 4'b0000, 4'hf, 4'b0010, 3'b010, 0, 0, 0);
    check("dm_alloc_read", 32'(o_ctl[C_PRD]), 1);
    step(0, 1, 4'b0000, 4'hf, 4'b0010, 3'b010, 1, 0, 0);
    step(0, 1, 4'b0010, 4'hf, 4'b0000, 3'b010, 0, 0, 0);
    check("dm_load_data", 32'(o_ld[11:8]), 32'(4'b0010));
    check("dm_load_dirty", 32'(o_ld[3:0]), 32'(4'b0010));
    check("dm_dirty_in", 32'(o_ctl[C_DIN]), 1);
    check("dm_wb_count", 32'(wb_count), 1);

    // Invalid way 2 wins over the PLRU choice; dirty way 0 is not written back.
    step(1, 0, 4'b0000, 4'b1011, 4'b0001, 3'b000, 0, 0, 0);
    step(1, 0, 4'b0000, 4'b1011, 4'b0001, 3'b000, 0, 0, 0);
    check("inv_way_sel", 32'(o_way), 2);
    check("inv_no_wb", 32'(o_ctl[C_PWR]), 0);
    step(1, 0, 4'b0000, 4'b1011, 4'b0001, 3'b000, 1, 0, 0);
    step(1, 0, 4'b0100, 4'b1111, 4'b0001, 3'b000, 0, 0, 0);

    // Reset held for two cycles in the middle of a fill.
    step(1, 0, 4'b0000, 4'hf, 4'h0, 3'b000, 0, 0, 0);
    step(1, 0, 4'b0000, 4'hf, 4'h0, 3'b000, 0, 0, 0);
    step(1, 0, 4'b0000, 4'hf, 4'h0, 3'b000, 1, 0, 1);
    step(1, 0, 4'b0000, 4'hf, 4'h0, 3'b000, 0, 0, 1);
    step(0, 0, 4'b0000, 4'hf, 4'h0, 3'b000, 0, 0, 0);
    check("rm_pmem_read", 32'(o_ctl[C_PRD]), 0);
    check("rm_hit_count", 32'(hit_count), 0);
    check("rm_miss_count", 32'(miss_count), 0);
    check("rm_wb_count", 32'(wb_count), 0);

    // Saturation, then clear_stats together with a hit.
    for (int i = 0; i < 20; i++) step(1, 0, 4'b0001, 4'hf, 4'h0, 3'b000, 0, 0, 0);
    check("sat_hit_count", 32'(hit_count), CMAX);
    step(1, 0, 4'b0001, 4'hf, 4'h0, 3'b000, 0, 1, 0);
    check("clr_hit_count", 32'(hit_count), 0);

    // Randomized traffic with requests held until completion.
    hr = 0; hw = 0;
    for (int c = 0; c < 3000; c++) begin
      if (m_phase == 0 && !hr && !hw) begin
        sel = int'($urandom % 4);
        hr = (sel == 1) || (sel == 3);
        hw = (sel == 2) || (sel == 3);
      end
      s_hit  = ($urandom % 5 < 2) ? 4'b0000 : (4'b0001 << ($urandom % 4));
      s_vld  = ($urandom % 3 == 0) ? 4'($urandom) : 4'hf;
      s_drt  = 4'($urandom);
      s_lru  = 3'($urandom);
      s_resp = ($urandom % 4 == 0);
      s_clr  = ($urandom % 40 == 0);
      s_rs   = ($urandom % 100 == 0);
      step(hr, hw, s_hit, s_vld, s_drt, s_lru, s_resp, s_clr, s_rs);
      if (x_resp || s_rs) begin
        hr = 0;
        hw = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
